// File: rtl/nf10_axil_master_pkg.sv
// Shared types and constants for the NF10 AXI4-Lite single-outstanding master.
package nf10_axil_master_pkg;

  // Transaction sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RESP
  } state_t;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Cycles a transaction may spend on the bus before it is aborted
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/nf10_axi_lite_master.sv
// NF10 AXI4-Lite master: turns a simple command/response handshake into one
// AXI4-Lite read or write transaction at a time.
// Optional feature: define NF10_AXIL_MASTER_TIMEOUT_EN to abort transactions
// that stay on the bus for C_TIMEOUT_CYCLES cycles (reported as SLVERR with
// rsp_timeout set). Without it the master waits indefinitely.
module nf10_axi_lite_master
  import nf10_axil_master_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  // command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  state_t state;

  // A write channel is finished once its valid has dropped or is being accepted now
  logic aw_done;
  logic w_done;
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] timeout_cnt;
  logic             on_bus;
  logic             finishing;

  // Cycles spent waiting on the slave count towards the timeout
  assign on_bus = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                  (state == ST_RD_REQ) || (state == ST_RD_DATA);

  // Only the final handshake of a transaction rescues the last allowed cycle
  assign finishing = ((state == ST_WR_RESP) && M_AXI_BVALID) ||
                     ((state == ST_RD_DATA) && M_AXI_RVALID);
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transaction sequencer with registered bus and response outputs
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= OKAY;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
      rsp_timeout   <= 1'b0;
      timeout_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
            timeout_cnt <= '0;
            rsp_timeout <= 1'b0;
`endif
            if (cmd_write) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= ST_WR_REQ;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= ST_RD_REQ;
            end
          end
        end

        ST_WR_REQ: begin
          // AW and W retire independently, in any order
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RD_REQ: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          // cmd_ready rises the cycle after the response is taken
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
      // Abort overrides whatever the state logic scheduled above
      if (on_bus) begin
        if ((timeout_cnt == CNT_LAST) && !finishing) begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
          rsp_valid     <= 1'b1;
          rsp_resp      <= SLVERR;
          rsp_rdata     <= '0;
          rsp_timeout   <= 1'b1;
          state         <= ST_RESP;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// Self-checking bench for nf10_axi_lite_master: a delay-configurable slave,
// a cycle-level expectation model derived from the slave delays, and a
// handful of directed transactions with hand-computed results.
module tb_nf10_axi_lite_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        axi_reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  nf10_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_TIMEOUT_CYCLES(TMO)
  ) dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- slave configuration (set between transactions) -------
  logic        cfg_write = 1'b0;
  logic [31:0] cfg_addr = '0, cfg_wdata = '0, cfg_rdata = '0;
  logic [3:0]  cfg_wstrb = '0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0, cfg_rsp_d = 0;
  logic        stray_b = 1'b0, stray_r = 1'b0;

  // Slave: each ready/valid fires after its configured number of wait cycles
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c, q_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; q_c = 0;
    forever begin
      @(posedge clk); #2;
      if (awvalid === 1'b1) begin awready = (aw_c == cfg_aw_d); aw_c++; end
      else begin awready = 1'b0; aw_c = 0; end
      if (wvalid === 1'b1) begin wready = (w_c == cfg_w_d); w_c++; end
      else begin wready = 1'b0; w_c = 0; end
      if (arvalid === 1'b1) begin arready = (ar_c == cfg_ar_d); ar_c++; end
      else begin arready = 1'b0; ar_c = 0; end
      if (bready === 1'b1) begin bvalid = (b_c == cfg_b_d); b_c++; end
      else begin bvalid = stray_b; b_c = 0; end
      bresp = bvalid ? cfg_bresp : 2'b11;
      if (rready === 1'b1) begin rvalid = (r_c == cfg_r_d); r_c++; end
      else begin rvalid = stray_r; r_c = 0; end
      rdata = rvalid ? cfg_rdata : 32'hBAD0_BAD0;
      rresp = rvalid ? cfg_rresp : 2'b10;
      if (rsp_valid === 1'b1) begin rsp_ready = (q_c == cfg_rsp_d); q_c++; end
      else begin rsp_ready = 1'b0; q_c = 0; end
    end
  end

  // ---------------- model of the transaction in flight --------------------
  logic        busy = 1'b0;
  int          acc_cyc = 0, cyc = 0;
  logic        m_write, m_tmo;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_resp;
  int          m_lat, m_aw, m_w, m_b, m_ar, m_r;
  int          done_cnt = 0, last_lat = 0, arv_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_resp = '0;
  logic        last_tmo = 1'b0, rsp_seen = 1'b0;

  // Latch the slave plan for an accepted command and derive the outcome
  task automatic model_accept();
    int ideal, m;
    m_write = cfg_write; m_addr = cfg_addr; m_wdata = cfg_wdata; m_wstrb = cfg_wstrb;
    m_aw = cfg_aw_d; m_w = cfg_w_d; m_b = cfg_b_d; m_ar = cfg_ar_d; m_r = cfg_r_d;
    m = (m_aw > m_w) ? m_aw : m_w;
    // cycles on the bus: request phase plus response phase
    ideal = m_write ? (m + 1) + (m_b + 1) : (m_ar + 1) + (m_r + 1);
`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
    m_tmo = (ideal > TMO);
`else
    m_tmo = 1'b0;
`endif
    m_lat   = m_tmo ? TMO + 1 : ideal + 1;
    m_resp  = m_tmo ? 2'b10 : (m_write ? cfg_bresp : cfg_rresp);
    m_rdata = (m_tmo || m_write) ? 32'h0 : cfg_rdata;
  endtask

  // Expected {AWVALID,WVALID,BREADY,ARVALID,RREADY} i cycles after accept
  function automatic logic [4:0] exp_chan(input int i);
    int m;
    logic [4:0] v;
    v = '0;
    m = (m_aw > m_w) ? m_aw : m_w;
    if (busy && i >= 1 && i <= m_lat - 1) begin
      if (m_write) begin
        v[4] = (i <= m_aw + 1);
        v[3] = (i <= m_w + 1);
        v[2] = (i >= m + 2) && (i <= m + m_b + 2);
      end else begin
        v[1] = (i <= m_ar + 1);
        v[0] = (i >= m_ar + 2) && (i <= m_ar + m_r + 2);
      end
    end
    return v;
  endfunction

  // Per-cycle comparison against the model
  initial begin
    logic prev_rst, armed;
    int i;
    prev_rst = 1'b0; armed = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin busy = 1'b0; armed = 1'b1; end
      if (armed) begin
        i = cyc - acc_cyc;
        if (prev_rst)
          check("reset_outputs",
                {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, awaddr, awvalid,
                 wdata, wstrb, wvalid, bready, araddr, arvalid, rready}, '0);
        check("cmd_ready", cmd_ready, !prev_rst && !busy);
        check("channels", {awvalid, wvalid, bready, arvalid, rready}, exp_chan(i));
        check("rsp_valid", rsp_valid, busy && (i >= m_lat));
        if (busy && rsp_valid) begin
          check("rsp_rdata", rsp_rdata, m_rdata);
          check("rsp_resp", rsp_resp, m_resp);
          check("rsp_timeout", rsp_timeout, m_tmo);
          rsp_cnt++;
          if (!rsp_seen) begin last_lat = i; rsp_seen = 1'b1; end
        end
        if (busy && awvalid) check("awaddr_wdata_wstrb", {awaddr, wdata, wstrb}, {m_addr, m_wdata, m_wstrb});
        if (busy && arvalid) begin check("araddr", araddr, m_addr); arv_cnt++; end
        if (!axi_reset) begin
          if (rsp_valid && rsp_ready && busy) begin
            busy = 1'b0; done_cnt++;
            last_rdata = rsp_rdata; last_resp = rsp_resp; last_tmo = rsp_timeout;
            $display("txn done: lat=%0d resp=%0d rdata=0x%08h timeout=%0d", last_lat, last_resp, last_rdata, last_tmo);
          end
          if (cmd_valid && cmd_ready) begin
            model_accept();
            busy = 1'b1; acc_cyc = cyc; arv_cnt = 0; rsp_cnt = 0; rsp_seen = 1'b0;
          end
        end
      end
      prev_rst = axi_reset;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int awd, input int wdl, input int bd,
                           input int ard, input int rd, input logic [1:0] resp,
                           input logic [31:0] rdat, input int rspd);
    int n;
    cfg_write = wr; cfg_addr = addr; cfg_wdata = wd; cfg_wstrb = strb;
    cfg_aw_d = awd; cfg_w_d = wdl; cfg_b_d = bd; cfg_ar_d = ard; cfg_r_d = rd;
    cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rdat; cfg_rsp_d = rspd;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_wstrb = ~strb;
  endtask

  task automatic wait_rsp(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 400) begin @(negedge clk); n++; end
    check("rsp_complete", done_cnt - start, 1);
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input int awd, input int wdl, input int bd,
                     input int ard, input int rd, input logic [1:0] resp,
                     input logic [31:0] rdat, input int rspd);
    int s;
    s = done_cnt;
    start_cmd(wr, addr, wd, strb, awd, wdl, bd, ard, rd, resp, rdat, rspd);
    wait_rsp(s);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1 axi_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back write with an always-ready slave
    txn(1'b1, 32'h7540_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    check("t1_latency", last_lat, 3);
    check("t1_resp", last_resp, 2'b00);
    check("t1_rdata", last_rdata, 32'h0);

    // Read with ARREADY held off five cycles
    txn(1'b0, 32'h7540_0004, 32'h0, 4'h0, 0, 0, 0, 5, 0, 2'b00, 32'h1234_5678, 0);
    check("t2_arvalid_cycles", arv_cnt, 6);
    check("t2_rdata", last_rdata, 32'h1234_5678);
    check("t2_latency", last_lat, 8);

    // Write data accepted four cycles before the address
    txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h5, 4, 0, 0, 0, 0, 2'b01, 32'h0, 0);
    check("t3_latency", last_lat, 7);
    check("t3_resp", last_resp, 2'b01);

    // Read error with the response stalled ten cycles
    txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hA5A5_0F0F, 10);
    check("t4_rsp_hold", rsp_cnt, 11);
    check("t4_resp", last_resp, 2'b11);
    check("t4_rdata", last_rdata, 32'hA5A5_0F0F);

    // Write with slow response and address before data
    txn(1'b1, 32'h0000_0300, 32'h0102_0304, 4'h3, 0, 2, 2, 0, 0, 2'b10, 32'h0, 1);
    check("t5_latency", last_lat, 7);

    // Stray BVALID/RVALID while idle must be ignored
    @(posedge clk); #1 stray_b = 1'b1; stray_r = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_b = 1'b0; stray_r = 1'b0;

    // Bus time of exactly TMO cycles completes normally
    txn(1'b1, 32'h0000_0400, 32'h1111_2222, 4'hF, 14, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    check("t7_latency", last_lat, 17);
    check("t7_timeout", last_tmo, 1'b0);

    // One cycle more: aborted when the timeout is built in
    txn(1'b1, 32'h0000_0500, 32'h3333_4444, 4'hF, 15, 0, 0, 0, 0, 2'b00, 32'h0, 0);
`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
    check("t8_timeout", last_tmo, 1'b1);
    check("t8_resp", last_resp, 2'b10);
`else
    check("t8_timeout", last_tmo, 1'b0);
    check("t8_latency", last_lat, 18);
`endif

    // AWREADY withheld
`ifdef NF10_AXIL_MASTER_TIMEOUT_EN
    txn(1'b1, 32'h0000_0600, 32'h5555_6666, 4'hF, 999, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    check("t9_latency", last_lat, 17);
    check("t9_timeout", last_tmo, 1'b1);
    check("t9_resp", last_resp, 2'b10);
`else
    txn(1'b1, 32'h0000_0600, 32'h5555_6666, 4'hF, 40, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    check("t9_latency", last_lat, 43);
    check("t9_timeout", last_tmo, 1'b0);
`endif

    // Reset in the middle of RD_DATA discards the read
    s = done_cnt;
    start_cmd(1'b0, 32'h0000_0700, 32'h0, 4'h0, 0, 0, 0, 0, 50, 2'b00, 32'h7777_8888, 0);
    repeat (4) @(negedge clk);
    check("t10_in_rd_data", rready, 1'b1);
    @(posedge clk); #1 axi_reset = 1'b1;
    @(posedge clk); #1 axi_reset = 1'b0;
    @(negedge clk);
    check("t10_reset_rready", rready, 1'b0);
    check("t10_reset_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    check("t10_release_cmd_ready", cmd_ready, 1'b1);
    check("t10_release_rsp_valid", rsp_valid, 1'b0);
    repeat (60) @(negedge clk);
    check("t10_no_stale_rsp", done_cnt, s);
    cfg_r_d = 0;

    // Normal operation after the abort
    txn(1'b0, 32'h0000_0800, 32'h0, 4'h0, 1, 0, 0, 1, 2, 2'b00, 32'h9ABC_DEF0, 2);
    check("t11_rdata", last_rdata, 32'h9ABC_DEF0);
    check("t11_latency", last_lat, 6);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nf10_axi_lite_master.md
NF10_AXI_LITE_MASTER -- requirements
Module: nf10_axi_lite_master

Interface
REQ-001 SHALL have parameters: C_M_AXI_ADDR_WIDTH, 32, address width; C_M_AXI_DATA_WIDTH, 32, data width; C_TIMEOUT_CYCLES, 1024, cycles before a transaction is aborted.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL have these ports:
- axi_aclk  in  1  sole clock, rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 each  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid / rsp_ready  out / in  1 each  response handshake.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  transaction was aborted by timeout.
- M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWREADY  out, out, in  32, 1, 1  write address channel.
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WREADY  out, out, out, in  32, 4, 1, 1  write data channel.
- M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY  in, in, out  2, 1, 1  write response channel.
- M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARREADY  out, out, in  32, 1, 1  read address channel.
- M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, M_AXI_RREADY  in, in, in, out  32, 2, 1, 1  read data channel.

Function
REQ-004 SHALL implement an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RESP; only one transaction is outstanding at a time.
REQ-005 SHALL assert cmd_ready only in IDLE. A command is accepted on the cycle cmd_valid and cmd_ready are both high; addr, wdata and wstrb are registered on that cycle.
REQ-006 SHALL, on an accepted write, enter WR_REQ and assert AWVALID and WVALID together on the next cycle.
REQ-007 SHALL track AW and W acceptance independently in WR_REQ: each valid drops after its own handshake. Both handshakes may complete in the same cycle or in either order. Moves to WR_RESP when both are done.
REQ-008 SHALL hold BREADY high in WR_RESP; on BVALID, capture BRESP, set rdata to 0 and go to RESP.
REQ-009 SHALL, on an accepted read, enter RD_REQ with ARVALID high until ARREADY, then enter RD_DATA with RREADY high. On RVALID, capture RDATA and RRESP and go to RESP.
REQ-010 SHALL assert rsp_valid in RESP and hold all rsp_* fields stable until rsp_ready. It returns to IDLE on that handshake; a new command is accepted no earlier than the following cycle.
REQ-011 SHALL never change AWADDR, WDATA, WSTRB or ARADDR while the matching valid is high.
REQ-012 SHALL ignore BVALID and RVALID in states where they are not expected, with no state change.
REQ-013 SHALL give a minimum latency from command accept to rsp_valid of 3 cycles, with a slave that is always ready and responds immediately.

Reset
REQ-014 SHALL, on reset, return to IDLE and clear every output to 0, including cmd_ready. cmd_ready rises on the first cycle after reset is deasserted.
REQ-015 SHALL, on reset mid-transaction, drop all valids on the next edge and discard the transaction without a response. This is a known protocol abort; the slave must be reset alongside.

Configuration
REQ-016 SHALL, when NF10_AXIL_MASTER_TIMEOUT_EN is defined:
- count cycles spent in WR_REQ, WR_RESP, RD_REQ and RD_DATA;
- at C_TIMEOUT_CYCLES, deassert all M_AXI valids and readys and enter RESP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
REQ-017 SHALL count from 0 on command accept; a count of exactly C_TIMEOUT_CYCLES-1 with a handshake in the same cycle completes normally.
REQ-018 SHALL, without the macro, contain no counter, tie rsp_timeout to 0 and wait indefinitely.

Structure
REQ-019 SHALL place the following in package nf10_axil_master_pkg:
- the state enum;
- response code constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
- the default timeout constant.
REQ-020 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-021 Write 0x75400010 / 0xDEADBEEF / strb 0xF, slave always ready, BRESP=00 -> rsp_valid 3 cycles after accept, resp=00, rdata=0.
REQ-022 Read 0x75400004, ARREADY delayed 5 cycles, RDATA=0x12345678, RRESP=00 -> ARVALID held 6 cycles with ARADDR stable; rsp_rdata=0x12345678.
REQ-023 Write with WREADY 4 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays until its own, BREADY only after both.
REQ-024 Read returning RRESP=2'b11, rsp_ready held low 10 cycles -> rsp fields stable for all 10 cycles, rsp_resp=11, cmd_ready low until the cycle after the handshake.
REQ-025 With NF10_AXIL_MASTER_TIMEOUT_EN and C_TIMEOUT_CYCLES=16, slave never asserts AWREADY -> after 16 cycles AWVALID=0, rsp_resp=10, rsp_timeout=1.
REQ-026 Reset asserted during RD_DATA -> next cycle all outputs 0; one cycle after reset release, cmd_ready=1 and no stale rsp_valid.
